cross_entropy_grad: RTL and testbench

//  Loss-gradient stage directly downstream of softmax. Consumes one softmax probability vector plus a

---
 rtl/cnn_pkg.sv | 34 +++
 rtl/cross_entropy_grad_argmax_tracker.sv | 43 ++++
 rtl/cross_entropy_grad.sv | 176 +++++++++++++++++
 tb/tb_cross_entropy_grad.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared fixed-point constants, saturating arithmetic and state encodings for the CNN
// training datapath.
package cnn_pkg;

    localparam int CNN_WIDTH     = 16;
    localparam int CNN_FRAC_BITS = 8;
    localparam logic signed [31:0] CNN_ONE = 32'sd1 <<< CNN_FRAC_BITS;

    typedef enum logic [1:0] {
        CE_IDLE = 2'd0,
        CE_SCAN = 2'd1,
        CE_DONE = 2'd2
    } ce_state_t;

    // a - b computed without overflow, then clamped to a signed w-bit range (w <= 32).
    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int                 w);
        logic signed [32:0] diff;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        diff = {a[31], a} - {b[31], b};
        hi   = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo   = -(33'sd1 <<< (w - 1));
        if (diff > hi) begin
            return hi[31:0];
        end else if (diff < lo) begin
            return lo[31:0];
        end else begin
            return diff[31:0];
        end
    endfunction

endpackage

// File: rtl/cross_entropy_grad_argmax_tracker.sv
// Sequential argmax over a stream of signed values; ties keep the earliest index.
// o_best_idx already includes the value presented this cycle.
module argmax_tracker
    import cnn_pkg::*;
#(
    parameter int WIDTH = CNN_WIDTH,
    parameter int IW    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_step,
    input  logic [IW-1:0]           i_idx,
    input  logic signed [WIDTH-1:0] i_value,
    output logic [IW-1:0]           o_best_idx
);

    logic [IW-1:0]           r_best_idx;
    logic signed [WIDTH-1:0] r_best_val;
    logic                    w_take;

    // Strictly greater replaces, so an equal later value never steals the lead.
    assign w_take     = i_step && (i_value > r_best_val);
    assign o_best_idx = w_take ? i_idx : r_best_idx;

    // Running best index/value; clear seeds with the first candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (i_clear) begin
            r_best_idx <= i_idx;
            r_best_val <= i_value;
        end else if (w_take) begin
            r_best_idx <= i_idx;
            r_best_val <= i_value;
        end else begin
            r_best_idx <= r_best_idx;
            r_best_val <= r_best_val;
        end
    end

endmodule

// File: rtl/cross_entropy_grad.sv
// Cross-entropy loss gradient (p - onehot(label)), one class per cycle, with argmax
// prediction and saturating sample/correct statistics.
module cross_entropy_grad
    import cnn_pkg::*;
#(
    parameter int WIDTH     = CNN_WIDTH,
    parameter int FRAC_BITS = CNN_FRAC_BITS,
    parameter int CLASSES   = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CLASSES-1:0][WIDTH-1:0]    softmax_in,
    input  logic [$clog2(CLASSES)-1:0]       label,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CLASSES-1:0][WIDTH-1:0]    error_out,
    output logic [$clog2(CLASSES)-1:0]       pred_class,
    output logic                             pred_correct,
    output logic                             label_err,
    input  logic                             clear_stats,
    output logic [CNT_WIDTH-1:0]             sample_count,
    output logic [CNT_WIDTH-1:0]             correct_count
);

    localparam int LW = $clog2(CLASSES);
    localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC_BITS;

    ce_state_t                     r_state;
    ce_state_t                     w_state_nxt;
    logic [CLASSES-1:0][WIDTH-1:0] r_p;
    logic [CLASSES-1:0][WIDTH-1:0] r_err;
    logic [LW-1:0]                 r_label;
    logic [LW-1:0]                 r_idx;
    logic [LW-1:0]                 r_pred;
    logic                          r_correct;
    logic                          r_label_err;
    logic                          r_out_valid;
    logic [CNT_WIDTH-1:0]          r_sample_cnt;
    logic [CNT_WIDTH-1:0]          r_correct_cnt;

    logic                          w_accept;
    logic                          w_retire;
    logic                          w_last;
    logic                          w_label_err;
    logic signed [WIDTH-1:0]       w_p_cur;
    logic signed [31:0]            w_sub;
    logic [LW-1:0]                 w_trk_idx;
    logic signed [WIDTH-1:0]       w_trk_val;
    logic [LW-1:0]                 w_best_idx;

    assign in_ready    = (r_state == CE_IDLE);
    assign w_accept    = in_valid && (r_state == CE_IDLE);
    assign w_retire    = out_ready && (r_state == CE_DONE);
    assign w_last      = (r_state == CE_SCAN) && (r_idx == LW'(CLASSES - 1));
    assign w_label_err = (32'(r_label) >= CLASSES);
    assign w_p_cur     = r_p[r_idx];
    assign w_sub       = ((r_idx == r_label) && !w_label_err) ? ONE : 32'sd0;

    assign out_valid     = r_out_valid;
    assign error_out     = r_err;
    assign pred_class    = r_pred;
    assign pred_correct  = r_correct;
    assign label_err     = r_label_err;
    assign sample_count  = r_sample_cnt;
    assign correct_count = r_correct_cnt;

    // Tracker is seeded from the live input on accept so SCAN needs no extra cycle.
    always_comb begin
        w_trk_idx = r_idx;
        w_trk_val = w_p_cur;
        if (w_accept) begin
            w_trk_idx = '0;
            w_trk_val = softmax_in[0];
        end else begin
            w_trk_idx = r_idx;
            w_trk_val = w_p_cur;
        end
    end

    argmax_tracker #(
        .WIDTH (WIDTH),
        .IW    (LW)
    ) u_argmax (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_accept),
        .i_step     (r_state == CE_SCAN),
        .i_idx      (w_trk_idx),
        .i_value    (w_trk_val),
        .o_best_idx (w_best_idx)
    );

    // Next-state logic for IDLE -> SCAN -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CE_IDLE: begin
                if (in_valid) w_state_nxt = CE_SCAN;
                else          w_state_nxt = CE_IDLE;
            end
            CE_SCAN: begin
                if (w_last) w_state_nxt = CE_DONE;
                else        w_state_nxt = CE_SCAN;
            end
            CE_DONE: begin
                if (out_ready) w_state_nxt = CE_IDLE;
                else           w_state_nxt = CE_DONE;
            end
            default: w_state_nxt = CE_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= CE_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Sample capture, per-class gradient and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p         <= '0;
            r_label     <= '0;
            r_idx       <= '0;
            r_err       <= '0;
            r_pred      <= '0;
            r_correct   <= 1'b0;
            r_label_err <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_p     <= softmax_in;
            r_label <= label;
            r_idx   <= '0;
        end else if (r_state == CE_SCAN) begin
            r_err[r_idx] <= WIDTH'(sat_sub(32'(w_p_cur), w_sub, WIDTH));
            r_idx        <= r_idx + LW'(1);
            if (w_last) begin
                r_pred      <= w_best_idx;
                r_correct   <= (w_best_idx == r_label) && !w_label_err;
                r_label_err <= w_label_err;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_retire) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Statistics: clear has priority over a coincident retire; increments saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_cnt  <= '0;
            r_correct_cnt <= '0;
        end else if (clear_stats) begin
            r_sample_cnt  <= '0;
            r_correct_cnt <= '0;
        end else if (w_retire) begin
            if (r_sample_cnt != {CNT_WIDTH{1'b1}}) r_sample_cnt <= r_sample_cnt + CNT_WIDTH'(1);
            else                                   r_sample_cnt <= r_sample_cnt;
            if (r_correct && (r_correct_cnt != {CNT_WIDTH{1'b1}}))
                r_correct_cnt <= r_correct_cnt + CNT_WIDTH'(1);
            else
                r_correct_cnt <= r_correct_cnt;
        end else begin
            r_sample_cnt  <= r_sample_cnt;
            r_correct_cnt <= r_correct_cnt;
        end
    end

endmodule

// File: tb/tb_cross_entropy_grad.sv
// Directed self-checking bench for cross_entropy_grad (CLASSES=10, ONE=256).
module tb_cross_entropy_grad;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [9:0][15:0]  softmax_in;
    logic [3:0]        label;
    logic              out_valid;
    logic              out_ready;
    logic [9:0][15:0]  error_out;
    logic [3:0]        pred_class;
    logic              pred_correct;
    logic              label_err;
    logic              clear_stats;
    logic [15:0]       sample_count;
    logic [15:0]       correct_count;

    int n_pass  = 0;
    int n_total = 0;

    cross_entropy_grad #(
        .WIDTH     (16),
        .FRAC_BITS (8),
        .CLASSES   (10),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .softmax_in    (softmax_in),
        .label         (label),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .error_out     (error_out),
        .pred_class    (pred_class),
        .pred_correct  (pred_correct),
        .label_err     (label_err),
        .clear_stats   (clear_stats),
        .sample_count  (sample_count),
        .correct_count (correct_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for a single cycle, then count cycles until out_valid (bounded).
    task automatic run_sample(input logic [9:0][15:0] pv, input logic [3:0] lb, output int lat);
        in_valid   = 1'b1;
        softmax_in = pv;
        label      = lb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || error_out !== '0 || pred_class !== 4'd0 ||
            pred_correct !== 1'b0 || label_err !== 1'b0 || sample_count !== 16'd0 || correct_count !== 16'd0)
            $display("FAIL reset_values: ov=%b ir=%b err=%h pred=%0d pc=%b le=%b cnt=%0d/%0d want all 0, ir=1",
                     out_valid, in_ready, error_out, pred_class, pred_correct, label_err, sample_count, correct_count);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_count !== 16'd0)
            $display("FAIL idle_after_reset: ov=%b ir=%b cnt=%0d want 0 1 0", out_valid, in_ready, sample_count);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [9:0][15:0] pv;
        int lat;
        int bad;
        for (int i = 0; i < 10; i++) pv[i] = 16'd25;
        pv[3] = 16'd31;
        run_sample(pv, 4'd3, lat);
        n_total++;
        if (lat !== 10) $display("FAIL basic_latency: got %0d want 10", lat);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (error_out[i] !== ((i == 3) ? 16'hFF1F : 16'd25)) bad++;
        n_total++;
        if (bad != 0) $display("FAIL basic_error: %0d wrong lanes, err=%h want e3=-225 rest 25", bad, error_out);
        else n_pass++;
        n_total++;
        if (pred_class !== 4'd3 || pred_correct !== 1'b1 || label_err !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL basic_pred: pred=%0d pc=%b le=%b ir=%b want 3 1 0 0", pred_class, pred_correct, label_err, in_ready);
        else n_pass++;
        handshake();
        n_total++;
        if (sample_count !== 16'd1 || correct_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_counts: cnt=%0d/%0d ov=%b ir=%b want 1/1 0 1", sample_count, correct_count, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_tie();
        logic [9:0][15:0] pv;
        int lat;
        for (int i = 0; i < 10; i++) pv[i] = 16'd7;
        pv[2] = 16'd100;
        pv[7] = 16'd100;
        run_sample(pv, 4'd7, lat);
        n_total++;
        if (lat !== 10 || pred_class !== 4'd2 || pred_correct !== 1'b0)
            $display("FAIL tie_pred: lat=%0d pred=%0d pc=%b want 10 2 0", lat, pred_class, pred_correct);
        else n_pass++;
        n_total++;
        if (error_out[7] !== 16'hFF64 || error_out[2] !== 16'd100 || error_out[0] !== 16'd7 || error_out[9] !== 16'd7)
            $display("FAIL tie_error: e7=%h e2=%h e0=%h e9=%h want ff64 0064 0007 0007",
                     error_out[7], error_out[2], error_out[0], error_out[9]);
        else n_pass++;
        handshake();
        n_total++;
        if (sample_count !== 16'd2 || correct_count !== 16'd1)
            $display("FAIL tie_counts: cnt=%0d/%0d want 2/1", sample_count, correct_count);
        else n_pass++;
    endtask

    task automatic test_saturation_label_err();
        logic [9:0][15:0] pv;
        int lat;
        int bad;
        pv = '0;
        pv[0] = 16'h8000;
        run_sample(pv, 4'd0, lat);
        n_total++;
        if (error_out[0] !== 16'h8000 || error_out[1] !== 16'd0 || pred_class !== 4'd1 || pred_correct !== 1'b0)
            $display("FAIL sat_low: e0=%h e1=%h pred=%0d pc=%b want 8000 0000 1 0",
                     error_out[0], error_out[1], pred_class, pred_correct);
        else n_pass++;
        handshake();
        for (int i = 0; i < 10; i++) pv[i] = 16'(i * 10 + 5);
        run_sample(pv, 4'd12, lat);
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (error_out[i] !== 16'(i * 10 + 5)) bad++;
        n_total++;
        if (bad != 0 || lat !== 10) $display("FAIL label_err_error: %0d wrong lanes lat=%0d err=%h want p unchanged", bad, lat, error_out);
        else n_pass++;
        n_total++;
        if (label_err !== 1'b1 || pred_correct !== 1'b0 || pred_class !== 4'd9)
            $display("FAIL label_err_flags: le=%b pc=%b pred=%0d want 1 0 9", label_err, pred_correct, pred_class);
        else n_pass++;
        handshake();
        n_total++;
        if (sample_count !== 16'd4 || correct_count !== 16'd1 || label_err !== 1'b1)
            $display("FAIL label_err_counts: cnt=%0d/%0d le=%b want 4/1 held 1", sample_count, correct_count, label_err);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [9:0][15:0] pv;
        int lat;
        int bad;
        for (int i = 0; i < 10; i++) pv[i] = 16'd50;
        pv[5] = 16'd60;
        run_sample(pv, 4'd5, lat);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                in_valid   = 1'b1;
                softmax_in = '0;
                label      = 4'd1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || error_out[5] !== 16'hFF3C || error_out[4] !== 16'd50 ||
                pred_class !== 4'd5 || pred_correct !== 1'b1 || sample_count !== 16'd4)
                bad++;
        end
        in_valid = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL stall_stable: %0d unstable cycles ov=%b ir=%b e5=%h pred=%0d cnt=%0d want 1 0 ff3c 5 4",
                               bad, out_valid, in_ready, error_out[5], pred_class, sample_count);
        else n_pass++;
        handshake();
        n_total++;
        if (sample_count !== 16'd5 || correct_count !== 16'd2)
            $display("FAIL stall_counts: cnt=%0d/%0d want 5/2", sample_count, correct_count);
        else n_pass++;
        repeat (12) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || error_out[5] !== 16'hFF3C || sample_count !== 16'd5)
            $display("FAIL stall_no_latch: ov=%b e5=%h cnt=%0d want 0 ff3c 5", out_valid, error_out[5], sample_count);
        else n_pass++;
    endtask

    task automatic test_abort_and_clear();
        logic [9:0][15:0] pv;
        int lat;
        for (int i = 0; i < 10; i++) pv[i] = 16'd20;
        pv[6] = 16'd40;
        in_valid   = 1'b1;
        softmax_in = pv;
        label      = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_count !== 16'd0 || correct_count !== 16'd0 ||
            error_out !== '0 || pred_class !== 4'd0)
            $display("FAIL abort_reset: ov=%b ir=%b cnt=%0d/%0d err=%h pred=%0d want 0 1 0/0 0 0",
                     out_valid, in_ready, sample_count, correct_count, error_out, pred_class);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || sample_count !== 16'd0)
            $display("FAIL abort_dropped: ov=%b cnt=%0d want 0 0", out_valid, sample_count);
        else n_pass++;
        run_sample(pv, 4'd6, lat);
        handshake();
        n_total++;
        if (lat !== 10 || sample_count !== 16'd1 || correct_count !== 16'd1)
            $display("FAIL post_abort_counts: lat=%0d cnt=%0d/%0d want 10 1/1", lat, sample_count, correct_count);
        else n_pass++;
        run_sample(pv, 4'd6, lat);
        out_ready   = 1'b1;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        n_total++;
        if (sample_count !== 16'd0 || correct_count !== 16'd0 || out_valid !== 1'b0)
            $display("FAIL clear_wins: cnt=%0d/%0d ov=%b want 0/0 0", sample_count, correct_count, out_valid);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        softmax_in  = '0;
        label       = 4'd0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_saturation_label_err();
        test_backpressure();
        test_abort_and_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
